// File: rtl/canvas_pkg.sv
`default_nettype none
// ============================================================================
// Module      : canvas_pkg
// Description : Shared canvas geometry, pixel type and painter FSM states.
//               CANVAS_DIM  - cells per canvas edge (28)
//               CANVAS_PIX  - total cells (784)
//               pixel_t     - 16-bit cell value
//               painter_state_t - IDLE / MAP / STAMP / STREAM
// Revision    : 1.0 - initial release
// ============================================================================
package canvas_pkg;

  localparam int CANVAS_DIM = 28;
  localparam int CANVAS_PIX = CANVAS_DIM * CANVAS_DIM;

  typedef logic [15:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MAP    = 2'd1,
    STAMP  = 2'd2,
    STREAM = 2'd3
  } painter_state_t;

endpackage
`default_nettype wire

// File: rtl/sat_add16.sv
`default_nettype none
// ============================================================================
// Module      : sat_add16
// Description : 16-bit unsigned add that clamps the result at i_max.
// Ports       : i_a, i_b  - addends
//               i_max     - saturation ceiling
//               o_sum     - min(i_a + i_b, i_max)
// Revision    : 1.0 - initial release
// ============================================================================
module sat_add16
  import canvas_pkg::*;
(
  input  pixel_t i_a,
  input  pixel_t i_b,
  input  pixel_t i_max,
  output pixel_t o_sum
);

  // One extra bit so a wrap past 16'hFFFF still clamps.
  logic [16:0] w_sum;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  assign o_sum = (w_sum > {1'b0, i_max}) ? i_max : w_sum[15:0];

endmodule
`default_nettype wire

// File: rtl/canvas_painter.sv
`default_nettype none
// ============================================================================
// Module      : canvas_painter
// Description : 28x28 paint canvas. A frame_tick while paint is held maps the
//               screen cursor to a cell (iterative subtraction) and stamps
//               the cell (plus its 4-neighbours when PAINTER_NEIGHBOR_EN is
//               defined) with saturating increments. read_start streams the
//               canvas out row-major over a valid/ready interface. clear
//               wipes the canvas and aborts any activity.
// Config      : `define PAINTER_NEIGHBOR_EN enables the 4-neighbour slots.
// Ports       : Clk, Reset (sync, active high)
//               frame_tick, CursorX, CursorY, paint, clear, read_start
//               canvas[x][y]  - registered canvas contents
//               pix_data, pix_valid, pix_ready, pix_last - readout stream
//               busy          - FSM not idle
//               stamp_done    - pulse in final stamp cycle
// Revision    : 1.0 - initial release
// ============================================================================
module canvas_painter
  import canvas_pkg::*;
#(
  parameter int     CANVAS_X0  = 200,
  parameter int     CANVAS_Y0  = 44,
  parameter int     CELL_PX    = 14,
  parameter pixel_t CENTER_INC = 16'h0400,
  parameter pixel_t NEIGH_INC  = 16'h0100,
  parameter pixel_t MAX_VAL    = 16'h07FF
) (
  input  logic                                     Clk,
  input  logic                                     Reset,
  input  logic                                     frame_tick,
  input  logic [9:0]                               CursorX,
  input  logic [9:0]                               CursorY,
  input  logic                                     paint,
  input  logic                                     clear,
  input  logic                                     read_start,
  output pixel_t [CANVAS_DIM-1:0][CANVAS_DIM-1:0]  canvas,
  output pixel_t                                   pix_data,
  output logic                                     pix_valid,
  input  logic                                     pix_ready,
  output logic                                     pix_last,
  output logic                                     busy,
  output logic                                     stamp_done
);

  localparam logic [10:0] c_x_lo    = 11'(CANVAS_X0);
  localparam logic [10:0] c_x_hi    = 11'(CANVAS_X0 + CANVAS_DIM * CELL_PX);
  localparam logic [10:0] c_y_lo    = 11'(CANVAS_Y0);
  localparam logic [10:0] c_y_hi    = 11'(CANVAS_Y0 + CANVAS_DIM * CELL_PX);
  localparam logic [9:0]  c_cell    = 10'(CELL_PX);
  localparam logic [4:0]  c_last_xy = 5'(CANVAS_DIM - 1);
  localparam logic [9:0]  c_last_bt = 10'(CANVAS_PIX - 1);
  localparam logic [5:0]  c_dim6    = 6'(CANVAS_DIM);
`ifdef PAINTER_NEIGHBOR_EN
  localparam logic [2:0]  c_last_slot = 3'd4;
`else
  localparam logic [2:0]  c_last_slot = 3'd0;
`endif

  painter_state_t r_state, w_state_nxt;

  pixel_t [CANVAS_DIM-1:0][CANVAS_DIM-1:0] r_canvas;
  logic [9:0] r_rx, r_ry;          // remaining offset during division
  logic       r_in_range;
  logic [4:0] r_cell_x, r_cell_y;  // quotient = target cell
  logic [2:0] r_slot;
  logic [4:0] r_sx, r_sy;          // coordinates of the beat on the bus
  logic [9:0] r_beat;
  pixel_t     r_pix_data;
  logic       r_pix_valid, r_pix_last;

  // ---------------------------------------------------------------- mapping
  logic       w_in_range, w_div_done, w_rx_done, w_ry_done;
  logic [9:0] w_off_x, w_off_y;

  assign w_in_range = ({1'b0, CursorX} >= c_x_lo) && ({1'b0, CursorX} < c_x_hi) &&
                      ({1'b0, CursorY} >= c_y_lo) && ({1'b0, CursorY} < c_y_hi);
  assign w_off_x    = CursorX - c_x_lo[9:0];
  assign w_off_y    = CursorY - c_y_lo[9:0];
  assign w_rx_done  = (r_rx < c_cell);
  assign w_ry_done  = (r_ry < c_cell);
  assign w_div_done = w_rx_done && w_ry_done;

  // ------------------------------------------------------------ stamp slots
  // Offsets are 6-bit two's complement so x-1 at column 0 lands on 63 and is
  // rejected by the same bound check as x+1 at column 27.
  logic [5:0] w_dx, w_dy, w_tx, w_ty;
  pixel_t     w_inc, w_cur, w_sum;
  logic       w_slot_ok, w_last_slot;

  always_comb begin
    w_dx  = 6'd0;
    w_dy  = 6'd0;
    w_inc = NEIGH_INC;
    case (r_slot)
      3'd0:    w_inc = CENTER_INC;
      3'd1:    w_dy  = 6'h3F;
      3'd2:    w_dy  = 6'd1;
      3'd3:    w_dx  = 6'h3F;
      3'd4:    w_dx  = 6'd1;
      default: w_inc = NEIGH_INC;
    endcase
  end

  assign w_tx        = {1'b0, r_cell_x} + w_dx;
  assign w_ty        = {1'b0, r_cell_y} + w_dy;
  assign w_slot_ok   = (w_tx < c_dim6) && (w_ty < c_dim6);
  assign w_cur       = r_canvas[w_tx[4:0]][w_ty[4:0]];
  assign w_last_slot = (r_slot == c_last_slot);

  sat_add16 u_sat (
    .i_a   (w_cur),
    .i_b   (w_inc),
    .i_max (MAX_VAL),
    .o_sum (w_sum)
  );

  // ---------------------------------------------------------------- stream
  logic       w_beat;
  logic [4:0] w_sx_nxt, w_sy_nxt;
  logic [9:0] w_beat_nxt;

  assign w_beat     = r_pix_valid && pix_ready;
  assign w_sx_nxt   = (r_sx == c_last_xy) ? 5'd0 : r_sx + 5'd1;
  assign w_sy_nxt   = (r_sx == c_last_xy) ? r_sy + 5'd1 : r_sy;
  assign w_beat_nxt = r_beat + 10'd1;

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (read_start)              w_state_nxt = STREAM;
        else if (frame_tick && paint) w_state_nxt = MAP;
      end
      MAP: begin
        if (!r_in_range)     w_state_nxt = IDLE;
        else if (w_div_done) w_state_nxt = STAMP;
      end
      STAMP: begin
        if (w_last_slot) w_state_nxt = IDLE;
      end
      STREAM: begin
        if (w_beat && r_pix_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (clear) w_state_nxt = IDLE;
  end

  // -------------------------------------------------------------- datapath
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_canvas    <= '0;
      r_rx        <= '0;
      r_ry        <= '0;
      r_in_range  <= 1'b0;
      r_cell_x    <= '0;
      r_cell_y    <= '0;
      r_slot      <= '0;
      r_sx        <= '0;
      r_sy        <= '0;
      r_beat      <= '0;
      r_pix_data  <= '0;
      r_pix_valid <= 1'b0;
      r_pix_last  <= 1'b0;
    end else if (clear) begin
      r_canvas    <= '0;
      r_slot      <= '0;
      r_pix_valid <= 1'b0;
      r_pix_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (read_start) begin
            r_sx        <= '0;
            r_sy        <= '0;
            r_beat      <= '0;
            r_pix_data  <= r_canvas[0][0];
            r_pix_valid <= 1'b1;
            r_pix_last  <= 1'b0;
          end else if (frame_tick && paint) begin
            r_rx       <= w_off_x;
            r_ry       <= w_off_y;
            r_in_range <= w_in_range;
            r_cell_x   <= '0;
            r_cell_y   <= '0;
            r_slot     <= '0;
          end
        end
        MAP: begin
          if (!w_rx_done) begin
            r_rx     <= r_rx - c_cell;
            r_cell_x <= r_cell_x + 5'd1;
          end
          if (!w_ry_done) begin
            r_ry     <= r_ry - c_cell;
            r_cell_y <= r_cell_y + 5'd1;
          end
        end
        STAMP: begin
          if (w_slot_ok) r_canvas[w_tx[4:0]][w_ty[4:0]] <= w_sum;
          r_slot <= w_last_slot ? 3'd0 : r_slot + 3'd1;
        end
        STREAM: begin
          if (w_beat) begin
            if (r_pix_last) begin
              r_pix_valid <= 1'b0;
              r_pix_last  <= 1'b0;
            end else begin
              r_sx       <= w_sx_nxt;
              r_sy       <= w_sy_nxt;
              r_beat     <= w_beat_nxt;
              r_pix_data <= r_canvas[w_sx_nxt][w_sy_nxt];
              r_pix_last <= (w_beat_nxt == c_last_bt);
            end
          end
        end
        default: r_slot <= '0;
      endcase
    end
  end

  assign canvas     = r_canvas;
  assign pix_data   = r_pix_data;
  assign pix_valid  = r_pix_valid;
  assign pix_last   = r_pix_last;
  assign busy       = (r_state != IDLE);
  // A clear in the final slot cancels the write, so no completion is flagged.
  assign stamp_done = (r_state == STAMP) && w_last_slot && !clear;

endmodule
`default_nettype wire

// File: tb/tb_canvas_painter.sv
`default_nettype none
// ============================================================================
// Module      : tb_canvas_painter
// Description : Directed self-checking bench for canvas_painter: reset state,
//               stamping and saturation, off-canvas cursors, row-major
//               readout with back-pressure, clear abort and reset mid-stamp.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_canvas_painter;
  import canvas_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset, frame_tick, paint, clear, read_start, pix_ready;
  logic [9:0] CursorX, CursorY;
  pixel_t [CANVAS_DIM-1:0][CANVAS_DIM-1:0] canvas;
  pixel_t     pix_data;
  logic       pix_valid, pix_last, busy, stamp_done;

  int checks = 0;
  int errors = 0;
  logic [15:0] m [CANVAS_DIM][CANVAS_DIM];

  always #5 Clk = ~Clk;

  canvas_painter dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .CursorX    (CursorX),
    .CursorY    (CursorY),
    .paint      (paint),
    .clear      (clear),
    .read_start (read_start),
    .canvas     (canvas),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_last   (pix_last),
    .busy       (busy),
    .stamp_done (stamp_done)
  );

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------------ canvas model
  task automatic model_clear;
    for (int x = 0; x < CANVAS_DIM; x++)
      for (int y = 0; y < CANVAS_DIM; y++) m[x][y] = 16'h0000;
  endtask

  task automatic madd(input int x, input int y, input int inc);
    int s;
    if (x >= 0 && x < CANVAS_DIM && y >= 0 && y < CANVAS_DIM) begin
      s = int'(m[x][y]) + inc;
      m[x][y] = (s > 'h7FF) ? 16'h07FF : 16'(s);
    end
  endtask

  task automatic model_stamp(input int cx, input int cy);
    int x, y;
    if (cx >= 200 && cx < 592 && cy >= 44 && cy < 436) begin
      x = (cx - 200) / 14;
      y = (cy - 44) / 14;
      madd(x, y, 'h400);
`ifdef PAINTER_NEIGHBOR_EN
      madd(x, y - 1, 'h100);
      madd(x, y + 1, 'h100);
      madd(x - 1, y, 'h100);
      madd(x + 1, y, 'h100);
`endif
    end
  endtask

  function automatic int canvas_diff();
    int n = 0;
    for (int x = 0; x < CANVAS_DIM; x++)
      for (int y = 0; y < CANVAS_DIM; y++)
        if (canvas[x][y] !== m[x][y]) n++;
    return n;
  endfunction

  // ------------------------------------------------------------------ steps
  task automatic do_stamp(input int cx, input int cy, output int sd, output int bc);
    CursorX    = 10'(cx);
    CursorY    = 10'(cy);
    paint      = 1'b1;
    frame_tick = 1'b1;
    tick;
    frame_tick = 1'b0;
    paint      = 1'b0;
    sd = 0;
    bc = 0;
    while (busy && bc < 100) begin
      if (stamp_done) sd++;
      bc++;
      tick;
    end
    model_stamp(cx, cy);
  endtask

  task automatic run_stream(input bit toggle, input bit with_paint, input string tag);
    int beats = 0, cyc = 0, bad_data = 0, bad_last = 0, bad_stall = 0;
    logic   stalled = 1'b0;
    pixel_t hold_d  = '0;
    logic   hold_l  = 1'b0;
    read_start = 1'b1;
    if (with_paint) begin
      CursorX = 10'd405; CursorY = 10'd250; paint = 1'b1; frame_tick = 1'b1;
    end
    pix_ready = 1'b1;
    tick;
    read_start = 1'b0; frame_tick = 1'b0; paint = 1'b0;
    while (beats < CANVAS_PIX && cyc < 4000) begin
      if (stalled && (pix_data !== hold_d || pix_last !== hold_l)) bad_stall++;
      stalled = pix_valid && !pix_ready;
      hold_d  = pix_data;
      hold_l  = pix_last;
      if (pix_valid && pix_ready) begin
        if (pix_data !== m[beats % CANVAS_DIM][beats / CANVAS_DIM]) bad_data++;
        if (pix_last !== (beats == CANVAS_PIX - 1)) bad_last++;
        beats++;
      end
      // Requests arriving mid-stream must be ignored.
      CursorX = 10'd405; CursorY = 10'd250;
      frame_tick = (cyc == 10);
      paint      = (cyc == 10);
      read_start = (cyc == 20);
      tick;
      cyc++;
      if (toggle) pix_ready = ~pix_ready;
    end
    frame_tick = 1'b0; paint = 1'b0; read_start = 1'b0;
    chk({tag, "_beats"}, beats, CANVAS_PIX);
    chk({tag, "_data"}, bad_data, 0);
    chk({tag, "_last"}, bad_last, 0);
    chk({tag, "_stall"}, bad_stall, 0);
    chk({tag, "_valid_drop"}, pix_valid, 0);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_canvas"}, canvas_diff(), 0);
  endtask

  // ----------------------------------------------------------------- main
  initial begin
    int sd, bc, n, beats;
    logic [15:0] nb;
    Reset = 1'b1; frame_tick = 1'b0; paint = 1'b0; clear = 1'b0;
    read_start = 1'b0; pix_ready = 1'b0; CursorX = '0; CursorY = '0;
    model_clear();
    tick;
    tick;
    chk("rst_busy", busy, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_last", pix_last, 0);
    chk("rst_data", pix_data, 0);
    chk("rst_done", stamp_done, 0);
    chk("rst_canvas", canvas_diff(), 0);
    Reset = 1'b0;
    tick;

`ifdef PAINTER_NEIGHBOR_EN
    nb = 16'h0100;
`else
    nb = 16'h0000;
`endif

    // Stamp in the middle of the canvas: cell (14,14).
    do_stamp(405, 250, sd, bc);
    chk("mid_done_cnt", sd, 1);
    chk("mid_busy_bound", (bc <= 33), 1);
    chk("mid_centre", canvas[14][14], 16'h0400);
    chk("mid_up", canvas[14][13], nb);
    chk("mid_right", canvas[15][14], nb);
    chk("mid_canvas", canvas_diff(), 0);

    // Asymmetric cell (3,20) catches x/y transposition in the readout.
    do_stamp(247, 329, sd, bc);
    chk("asym_done_cnt", sd, 1);
    chk("asym_centre", canvas[3][20], 16'h0400);

    // Corner cell twice: saturation and off-grid neighbours.
    do_stamp(207, 51, sd, bc);
    chk("corner1", canvas[0][0], 16'h0400);
    do_stamp(207, 51, sd, bc);
    chk("corner2_sat", canvas[0][0], 16'h07FF);
    chk("corner_x1", canvas[1][0], nb << 1);
    chk("corner_y1", canvas[0][1], nb << 1);
    chk("corner_canvas", canvas_diff(), 0);

    // Off-canvas cursors.
    do_stamp(199, 100, sd, bc);
    chk("oor_lo_done", sd, 0);
    chk("oor_lo_busy", (bc <= 2), 1);
    do_stamp(592, 100, sd, bc);
    chk("oor_hi_done", sd, 0);
    chk("oor_hi_busy", (bc <= 2), 1);
    do_stamp(300, 436, sd, bc);
    chk("oor_y_done", sd, 0);
    chk("oor_canvas", canvas_diff(), 0);

    // read_start wins over a simultaneous paint; ready toggles every cycle.
    run_stream(1'b1, 1'b1, "stream_toggle");

    // Clear at beat 300.
    read_start = 1'b1;
    pix_ready  = 1'b1;
    tick;
    read_start = 1'b0;
    beats = 0;
    n = 0;
    while (beats < 300 && n < 1000) begin
      if (pix_valid && pix_ready) beats++;
      tick;
      n++;
    end
    chk("clr_beat300", pix_data, m[300 % CANVAS_DIM][300 / CANVAS_DIM]);
    clear     = 1'b1;
    pix_ready = 1'b0;
    tick;
    clear = 1'b0;
    model_clear();
    chk("clr_valid", pix_valid, 0);
    chk("clr_idle", busy, 0);
    chk("clr_canvas", canvas_diff(), 0);
    run_stream(1'b0, 1'b0, "stream_zero");

    // Reset together with clear while a stamp is in STAMP.
    do_stamp(247, 329, sd, bc);
    chk("pre_rst_cell", canvas[3][20], 16'h0400);
    CursorX = 10'd405; CursorY = 10'd250; paint = 1'b1; frame_tick = 1'b1;
    tick;
    frame_tick = 1'b0; paint = 1'b0;
    n = 0;
`ifdef PAINTER_NEIGHBOR_EN
    while (canvas[14][14] === 16'h0000 && n < 40) begin tick; n++; end
`else
    while (!stamp_done && n < 40) begin tick; n++; end
`endif
    chk("mid_stamp_busy", busy, 1);
    Reset = 1'b1;
    clear = 1'b1;
    tick;
    Reset = 1'b0;
    clear = 1'b0;
    model_clear();
    chk("rst2_canvas", canvas_diff(), 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_done", stamp_done, 0);
    chk("rst2_valid", pix_valid, 0);
    chk("rst2_data", pix_data, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
